param_input_collector: RTL and testbench
========================================

Name: param_input_collector

Overview:
- Serial-to-parallel loader for the cipher front end. Accepts narrow plaintext and key chunks over a valid/ready stream and assembles them into one full data block and one full key.
- Presents the assembled block and key with an output valid/ready handshake.
- Generalises the fixed 32-bit data / 64-bit key loader:
  - all widths are parametrised;
  - fill order is selectable;
  - input and output both support backpressure;
  - an optional stall timeout is available.

Parameters:
- DATA_W, 32, assembled data block width.
- KEY_W, 64, assembled key width.
- PT_CHUNK, 4, plaintext bits per input beat.
- KEY_CHUNK, 8, key bits per input beat.
- MSB_FIRST, 1, 1 = beat 0 fills the top chunk; 0 = beat 0 fills chunk [CHUNK-1:0].
- TIMEOUT, 16, idle-cycle limit for the optional timeout (only used with the macro).
- Constraint: DATA_W/PT_CHUNK == KEY_W/KEY_CHUNK == BEATS, with BEATS >= 2. Any other setting is an elaboration error.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, begin a new collection (sampled in IDLE only).
- in_valid, input, 1, pt_in/key_in carry a beat.
- in_ready, output, 1, collector accepts a beat this cycle.
- pt_in, input, PT_CHUNK, plaintext chunk.
- key_in, input, KEY_CHUNK, key chunk.
- data, output, DATA_W, assembled block.
- key_out, output, KEY_W, assembled key.
- out_valid, output, 1, data/key_out complete and stable.
- out_ready, input, 1, consumer takes the block.
- busy, output, 1, high in COLLECT or HOLD.
- beat_cnt, output, clog2(BEATS)+1, beats accepted in the current collection.
- done, output, 1, one-cycle pulse when out_valid && out_ready.
- err, output, 1, one-cycle timeout pulse (tied 0 without the macro).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - state = IDLE;
  - data = 0, key_out = 0, beat_cnt = 0;
  - in_ready = 0, out_valid = 0, busy = 0, done = 0, err = 0.
- Reset has priority over all other inputs in any state, including mid-collection and HOLD. A partial block is discarded.
- FSM states:
  - IDLE:
    - in_ready = 0.
    - start = 1 → COLLECT next cycle; beat_cnt, data and key_out clear to 0 on that edge.
    - in_valid in IDLE, including in the start cycle, is ignored.
  - COLLECT:
    - in_ready = 1 (combinational from state only).
    - An accepted beat (in_valid && in_ready) writes pt_in and key_in at chunk index i = beat_cnt. With MSB_FIRST = 1 the write position is BEATS-1-i; otherwise it is i.
    - Each accepted beat increments beat_cnt. Unwritten chunks stay 0.
    - The accepted beat with beat_cnt == BEATS-1 → HOLD next cycle; beat_cnt reads BEATS.
    - start is ignored.
  - HOLD:
    - out_valid = 1; data and key_out are frozen; in_ready = 0.
    - out_ready = 1 → done pulses in that same cycle (combinational: out_valid && out_ready), then IDLE next cycle. beat_cnt holds BEATS until the next start clears it.
    - data and key_out keep their values after leaving HOLD until the next start.
    - start is ignored in HOLD, including a start in the handshake cycle. A new start is honoured only once in IDLE, so back-to-back blocks cost one IDLE cycle.
- Latency with in_valid held high:
  - start at cycle 0;
  - beats accepted at cycles 1..BEATS;
  - out_valid first high at cycle BEATS+1. With defaults this is cycle 9.
- Gaps in in_valid stall the collection without corrupting it. Only accepted beats advance beat_cnt.
- A single reset/clear path is used; no partial-width arithmetic wraps.

Optional Feature:
- Macro: COLLECT_TIMEOUT_EN.
- Defined:
  - In COLLECT, a stall counter counts consecutive cycles with no accepted beat and resets to 0 on each accepted beat.
  - When it reaches TIMEOUT, err pulses for one cycle, state returns to IDLE, and beat_cnt, data and key_out clear to 0. out_valid never asserts for that collection.
  - The counter does not run in IDLE or HOLD.
- Undefined:
  - No stall counter is built; err is constant 0.
  - COLLECT waits indefinitely.

Test Plan:
- Defaults, MSB_FIRST = 1; reset, start at cycle 0, in_valid held high, pt_in = 1,2..8, key_in = 0x11,0x22..0x88 → out_valid at cycle 9; data = 0x12345678; key_out = 0x1122334455667788; beat_cnt = 8.
- Same stimulus with MSB_FIRST = 0 → data = 0x87654321; key_out = 0x8877665544332211.
- in_valid toggled 1,0,1,0…; out_ready held 0 for 5 cycles after out_valid, then 1 → values identical to test 1; data stable all 5 hold cycles; done pulses exactly once, in the cycle out_ready rises; IDLE next cycle.
- Reset asserted after 3 accepted beats → next cycle: all outputs at reset values. A subsequent full 8-beat load yields a correct block with no residue of the aborted beats.
- start held high throughout COLLECT and HOLD, with in_valid asserted in the start cycle → start-cycle beat not captured; no restart mid-collection; only the start seen in IDLE after the handshake begins block 2.
- COLLECT_TIMEOUT_EN, TIMEOUT = 16; 2 beats then in_valid = 0 → err pulses exactly once, 16 cycles after the last accepted beat; state IDLE, beat_cnt = 0, out_valid never asserted.

Source files
------------

// File: rtl/param_input_collector.sv
// Serial-to-parallel loader: assembles BEATS plaintext/key chunks into one data block and key.
// Optional stall timeout is compiled in with `define COLLECT_TIMEOUT_EN.
module param_input_collector #(
    parameter int DATA_W    = 32,
    parameter int KEY_W     = 64,
    parameter int PT_CHUNK  = 4,
    parameter int KEY_CHUNK = 8,
    parameter int MSB_FIRST = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [PT_CHUNK-1:0]                       pt_in,
    input  logic [KEY_CHUNK-1:0]                      key_in,
    output logic [DATA_W-1:0]                         data,
    output logic [KEY_W-1:0]                          key_out,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      busy,
    output logic [$clog2(DATA_W/PT_CHUNK):0]          beat_cnt,
    output logic                                      done,
    output logic                                      err
);
    localparam int BEATS = DATA_W / PT_CHUNK;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    if ((DATA_W % PT_CHUNK) != 0 || (KEY_W % KEY_CHUNK) != 0 ||
        (DATA_W / PT_CHUNK) != (KEY_W / KEY_CHUNK) || BEATS < 2 || TIMEOUT < 1) begin : g_cfg_err
        $error("param_input_collector: inconsistent chunk/beat configuration");
    end

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             clear;
    logic             timeout_hit;
    logic [CNT_W-1:0] pos;

    assign accept = in_valid && (state == COLLECT);
    assign pos    = (MSB_FIRST != 0) ? (LAST - beat_cnt) : beat_cnt;

`ifdef COLLECT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] stall_cnt;

    // Counts consecutive beat-less COLLECT cycles; idle elsewhere.
    always_ff @(posedge clk) begin
        if (reset || state != COLLECT || accept) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == COLLECT) && !accept && (stall_cnt == TO_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign err  = timeout_hit;
    assign done = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COLLECT;
                    clear     = 1'b1;
                end
            end
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && beat_cnt == LAST) begin
                    state_nxt = HOLD;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                    clear     = 1'b1;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Block, key and beat count share one clear path (reset, start, timeout).
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            data     <= '0;
            key_out  <= '0;
            beat_cnt <= '0;
        end else if (accept) begin
            for (int b = 0; b < BEATS; b++) begin
                if (pos == CNT_W'(b)) begin
                    data[b*PT_CHUNK +: PT_CHUNK]     <= pt_in;
                    key_out[b*KEY_CHUNK +: KEY_CHUNK] <= key_in;
                end
            end
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_param_input_collector.sv
// Directed bench for param_input_collector: MSB-first and LSB-first instances share stimulus.
// Covers latency, gaps, output backpressure, reset abort, start masking and the stall timeout.
module tb_param_input_collector;
    logic        clk = 1'b0;
    logic        reset, start, in_valid, out_ready;
    logic [3:0]  pt_in;
    logic [7:0]  key_in;

    logic        in_ready_m, out_valid_m, busy_m, done_m, err_m;
    logic        in_ready_l, out_valid_l, busy_l, done_l, err_l;
    logic [31:0] data_m, data_l;
    logic [63:0] key_m, key_l;
    logic [3:0]  beat_cnt_m, beat_cnt_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    param_input_collector #(.MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_m),
        .pt_in(pt_in), .key_in(key_in), .data(data_m), .key_out(key_m), .out_valid(out_valid_m),
        .out_ready(out_ready), .busy(busy_m), .beat_cnt(beat_cnt_m), .done(done_m), .err(err_m)
    );

    param_input_collector #(.MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_l),
        .pt_in(pt_in), .key_in(key_in), .data(data_l), .key_out(key_l), .out_valid(out_valid_l),
        .out_ready(out_ready), .busy(busy_l), .beat_cnt(beat_cnt_l), .done(done_l), .err(err_l)
    );

    typedef struct packed {
        logic [31:0] pt_seq;     // beat i = nibble i counted from the left
        logic [63:0] key_seq;    // beat i = byte i counted from the left
        logic        gaps;
        logic [3:0]  hold_n;
        logic        start_hold;
        logic [31:0] d_msb;
        logic [63:0] k_msb;
        logic [31:0] d_lsb;
        logic [63:0] k_lsb;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, settle, then the caller samples.
    task automatic step(input logic s, input logic v, input logic [3:0] p, input logic [7:0] k,
                        input logic r);
        @(negedge clk);
        reset     = 1'b0;
        start     = s;
        in_valid  = v;
        pt_in     = p;
        key_in    = k;
        out_ready = r;
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data_m"}, 64'(data_m), 64'd0);
        chk({tag, "_key_l"}, key_l, 64'd0);
        chk({tag, "_beat_cnt"}, 64'(beat_cnt_m), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready_m), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid_m), 64'd0);
        chk({tag, "_busy"}, 64'(busy_m), 64'd0);
        chk({tag, "_done"}, 64'(done_m), 64'd0);
        chk({tag, "_err"}, 64'(err_m), 64'd0);
    endtask

    task automatic run_load(input vec_t v, input logic skip_start);
        if (!skip_start) begin
            // Start cycle carries a junk beat that must not be captured.
            step(1'b1, 1'b1, 4'hF, 8'hEE, 1'b0);
            chk("idle_in_ready", 64'(in_ready_m), 64'd0);
            chk("idle_busy", 64'(busy_m), 64'd0);
        end
        for (int i = 0; i < 8; i++) begin
            step(v.start_hold, 1'b1, v.pt_seq[31-4*i -: 4], v.key_seq[63-8*i -: 8], 1'b0);
            chk("col_in_ready", 64'(in_ready_m), 64'd1);
            chk("col_out_valid", 64'(out_valid_l), 64'd0);
            chk("col_beat_cnt", 64'(beat_cnt_m), 64'(i));
            if (i == 0) begin
                chk("clear_data_m", 64'(data_m), 64'd0);
                chk("clear_key_l", key_l, 64'd0);
            end
            if (v.gaps && i < 7) begin
                step(v.start_hold, 1'b0, 4'hA, 8'h5C, 1'b0);
                chk("gap_beat_cnt", 64'(beat_cnt_l), 64'(i + 1));
                chk("gap_busy", 64'(busy_m), 64'd1);
            end
        end
        for (int h = 0; h < int'(v.hold_n); h++) begin
            step(v.start_hold, 1'b1, 4'h3, 8'h3C, 1'b0);
            chk("hold_out_valid", 64'(out_valid_m), 64'd1);
            chk("hold_done", 64'(done_m), 64'd0);
            chk("hold_in_ready", 64'(in_ready_l), 64'd0);
            chk("hold_data_m", 64'(data_m), 64'(v.d_msb));
            chk("hold_key_l", key_l, v.k_lsb);
            chk("hold_beat_cnt", 64'(beat_cnt_m), 64'd8);
        end
        step(v.start_hold, 1'b1, 4'h3, 8'h3C, 1'b1);
        chk("hs_out_valid", 64'(out_valid_l), 64'd1);
        chk("hs_done_m", 64'(done_m), 64'd1);
        chk("hs_done_l", 64'(done_l), 64'd1);
        chk("hs_data_m", 64'(data_m), 64'(v.d_msb));
        chk("hs_key_m", key_m, v.k_msb);
        chk("hs_data_l", 64'(data_l), 64'(v.d_lsb));
        chk("hs_key_l", key_l, v.k_lsb);
        step(v.start_hold, 1'b0, 4'h0, 8'h00, 1'b0);
        chk("post_out_valid", 64'(out_valid_m), 64'd0);
        chk("post_done", 64'(done_m), 64'd0);
        chk("post_busy", 64'(busy_l), 64'd0);
        chk("post_beat_cnt", 64'(beat_cnt_m), 64'd8);
        chk("post_data_m", 64'(data_m), 64'(v.d_msb));
        chk("post_key_l", key_l, v.k_lsb);
    endtask

    initial begin
        vecs[0] = '{pt_seq: 32'h12345678, key_seq: 64'h1122334455667788, gaps: 1'b0,
                    hold_n: 4'd0, start_hold: 1'b0,
                    d_msb: 32'h12345678, k_msb: 64'h1122334455667788,
                    d_lsb: 32'h87654321, k_lsb: 64'h8877665544332211};
        vecs[1] = '{pt_seq: 32'h12345678, key_seq: 64'h1122334455667788, gaps: 1'b1,
                    hold_n: 4'd5, start_hold: 1'b0,
                    d_msb: 32'h12345678, k_msb: 64'h1122334455667788,
                    d_lsb: 32'h87654321, k_lsb: 64'h8877665544332211};
        vecs[2] = '{pt_seq: 32'hF0A5C396, key_seq: 64'hFF00A55A01807EE7, gaps: 1'b0,
                    hold_n: 4'd2, start_hold: 1'b1,
                    d_msb: 32'hF0A5C396, k_msb: 64'hFF00A55A01807EE7,
                    d_lsb: 32'h693C5A0F, k_lsb: 64'hE77E80015AA500FF};
        vecs[3] = '{pt_seq: 32'h87654321, key_seq: 64'h8877665544332211, gaps: 1'b1,
                    hold_n: 4'd1, start_hold: 1'b0,
                    d_msb: 32'h87654321, k_msb: 64'h8877665544332211,
                    d_lsb: 32'h12345678, k_lsb: 64'h1122334455667788};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pt_in = 4'h0; key_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset_state("rst0");

        // Table loads; vecs[2] holds start high, so its trailing IDLE start chains vecs[3].
        for (int n = 0; n < 4; n++) begin
            run_load(vecs[n], (n == 3) ? 1'b1 : 1'b0);
        end

        // Abort after three beats, then reload cleanly.
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'h9, 8'h99, 1'b0);
        @(negedge clk);
        reset = 1'b1; start = 1'b1; in_valid = 1'b1;
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        chk_reset_state("rst_mid");
        run_load(vecs[0], 1'b0);

        // Two beats then a long stall.
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 4'h1, 8'h11, 1'b0);
        step(1'b0, 1'b1, 4'h2, 8'h22, 1'b0);
`ifdef COLLECT_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
            chk("to_err", 64'(err_m), (k == 16) ? 64'd1 : 64'd0);
            chk("to_out_valid", 64'(out_valid_m), 64'd0);
        end
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
        chk("to_busy", 64'(busy_m), 64'd0);
        chk("to_beat_cnt", 64'(beat_cnt_m), 64'd0);
        chk("to_data", 64'(data_m), 64'd0);
        chk("to_err_after", 64'(err_l), 64'd0);
        chk("to_out_valid_after", 64'(out_valid_l), 64'd0);
`else
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
            chk("stall_err", 64'(err_m), 64'd0);
            chk("stall_busy", 64'(busy_m), 64'd1);
            chk("stall_beat_cnt", 64'(beat_cnt_m), 64'd2);
        end
        for (int i = 2; i < 8; i++) begin
            step(1'b0, 1'b1, 4'(i + 1), 8'((i + 1) * 17), 1'b0);
        end
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
        chk("stall_done", 64'(done_m), 64'd1);
        chk("stall_data_m", 64'(data_m), 64'h12345678);
        chk("stall_key_m", key_m, 64'h1122334455667788);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
